// File: rtl/nibble_tx_pkg.sv
// Shared types and constants for the nibble serial transmitter.
package nibble_tx_pkg;

    localparam int unsigned NIBBLE_W  = 4;
    localparam int unsigned BIT_IDX_W = 2;
    localparam logic        LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // A is bit 0 so that a right shift presents A, B, C, D in order.
    function automatic logic [NIBBLE_W-1:0] pack_nibble(
        input logic a,
        input logic b,
        input logic c,
        input logic d
    );
        return {d, c, b, a};
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Per-bit cycle counter for the nibble transmitter; bit_tick marks the last
// cycle of a bit, tick_next_c predicts it for the following cycle.
module tx_bit_timer
    import nibble_tx_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick,
    output logic tick_next_c
);

    localparam int unsigned     CNT_W    = $clog2(BIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick    = (cnt_q == CNT_LAST);
    assign tick_next_c = (cnt_d == CNT_LAST);

endmodule

// File: rtl/nibble_serial_tx.sv
// Serialises a latched nibble A..D as start, data (A first), [parity], stop.
// Define PARITY_EN to insert the parity bit; ODD_PARITY then selects its sense.
module nibble_serial_tx
    import nibble_tx_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic Y,
    output logic busy,
    output logic done
);

    if (BIT_CYCLES < 1 || ODD_PARITY > 1) begin : g_bad_cfg
        $error("nibble_serial_tx: BIT_CYCLES must be >= 1 and ODD_PARITY 0 or 1");
    end

    localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(NIBBLE_W - 1);

    tx_state_e             state_q;
    tx_state_e             state_d;
    logic [NIBBLE_W-1:0]   shreg_q;
    logic [NIBBLE_W-1:0]   shreg_d;
    logic [BIT_IDX_W-1:0]  idx_q;
    logic [BIT_IDX_W-1:0]  idx_d;
    logic                  y_q;
    logic                  y_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  done_q;
    logic                  done_d;
`ifdef PARITY_EN
    logic                  parity_q;
    logic                  parity_d;
`endif

    logic bit_tick;
    logic tick_next_c;

    tx_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (state_d != state_q),
        .bit_tick    (bit_tick),
        .tick_next_c (tick_next_c)
    );

    // Next-state, shift register and bit index.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
`ifdef PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = START;
                    shreg_d  = pack_nibble(A, B, C, D);
`ifdef PARITY_EN
                    parity_d = (^{A, B, C, D}) ^ 1'(ODD_PARITY);
`endif
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d   = idx_q + BIT_IDX_W'(1);
                        shreg_d = {1'b0, shreg_q[NIBBLE_W-1:1]};
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from next-cycle state so the flops present them in step.
    always_comb begin
        y_d    = LINE_IDLE;
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && tick_next_c;
        case (state_d)
            START:   y_d = ~LINE_IDLE;
            DATA:    y_d = shreg_d[0];
`ifdef PARITY_EN
            PARITY:  y_d = parity_d;
`endif
            default: y_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            idx_q    <= '0;
            y_q      <= LINE_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign Y    = y_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Scoreboard bench for nibble_serial_tx: two instances (BIT_CYCLES 1 and 3)
// share stimulus; a receiver decode of the fast instance feeds a 0110 detector.
module tb_nibble_serial_tx;

`ifdef PARITY_EN
    localparam int NBITS = 7;
`else
    localparam int NBITS = 6;
`endif
    localparam logic ODD = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, a, b, c, d;
    logic y1, busy1, done1;
    logic y3, busy3, done3;

    nibble_serial_tx #(.BIT_CYCLES(1), .ODD_PARITY(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start),
        .A(a), .B(b), .C(c), .D(d),
        .Y(y1), .busy(busy1), .done(done1)
    );

    nibble_serial_tx #(.BIT_CYCLES(3), .ODD_PARITY(0)) u_dut3 (
        .clk(clk), .rst(rst), .start(start),
        .A(a), .B(b), .C(c), .D(d),
        .Y(y3), .busy(busy3), .done(done3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Expected per-cycle {Y, busy, done}; empty queue means the line is idle.
    logic [2:0] sb1[$];
    logic [2:0] sb3[$];
    logic       det_q[$];
    logic [7:0] rx_s;
    int         rx_n;
    logic [3:0] cur_nib;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // nib is {D,C,B,A}; k is the cycle within the frame.
    function automatic logic [2:0] frame_entry(input int bc, input logic [3:0] nib, input int k);
        int   bi;
        logic yb;
        logic [3:0] nv;
        nv = nib;
        bi = k / bc;
        if (bi == 0)                     yb = 1'b0;
        else if (bi <= 4)                yb = nv[bi-1];
        else if (NBITS == 7 && bi == 5)  yb = (^nv) ^ ODD;
        else                             yb = 1'b1;
        return {yb, 1'b1, (k == NBITS*bc - 1)};
    endfunction

    task automatic step(input logic r, input logic s, input logic [3:0] nib);
        logic [2:0] e1, e3;
        logic       idle1, idle3;
        logic       det_got;
        @(negedge clk);
        idle1 = (sb1.size() == 0);
        idle3 = (sb3.size() == 0);
        e1 = idle1 ? 3'b100 : sb1.pop_front();
        e3 = idle3 ? 3'b100 : sb3.pop_front();
        check("y_bc1",    y1,    e1[2]);
        check("busy_bc1", busy1, e1[1]);
        check("done_bc1", done1, e1[0]);
        check("y_bc3",    y3,    e3[2]);
        check("busy_bc3", busy3, e3[1]);
        check("done_bc3", done3, e3[0]);
        if (busy1 === 1'b1 && rx_n < 8) begin
            rx_s[rx_n] = y1;
            rx_n++;
        end
        if (done1 === 1'b1) begin
            det_got = (rx_s[4:1] == 4'b0110);
            if (det_q.size() == 0) check("det_unexpected_frame", 32'd1, 32'd0);
            else                   check("detector", det_got, det_q.pop_front());
            rx_n = 0;
        end
        rst = r;
        start = s;
        {d, c, b, a} = nib;
        cur_nib = nib;
        if (r) begin
            sb1.delete();
            sb3.delete();
            det_q.delete();
            rx_n = 0;
        end else if (s) begin
            if (idle1) begin
                for (int k = 0; k < NBITS; k++) sb1.push_back(frame_entry(1, nib, k));
                det_q.push_back(nib == 4'b0110);
            end
            if (idle3) begin
                for (int k = 0; k < NBITS*3; k++) sb3.push_back(frame_entry(3, nib, k));
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (sb1.size() == 0 && sb3.size() == 0) break;
            step(1'b0, 1'b0, cur_nib);
        end
        check("drain_bounded", 32'(sb1.size() + sb3.size()), 32'd0);
        step(1'b0, 1'b0, cur_nib);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; {d, c, b, a} = 4'b0000;
        cur_nib = 4'b0000; rx_s = '0; rx_n = 0;
        repeat (2) @(posedge clk);
        // Reset state observed while rst is held.
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b0110);
        step(1'b0, 1'b0, 4'b0110);

        // Basic frame with A..D = 0110 ({D,C,B,A} = 0110).
        step(1'b0, 1'b1, 4'b0110);
        drain();

        // Late input change plus start pulses while busy (cycle 6 is the done cycle at BC=1).
        step(1'b0, 1'b1, 4'b0110);
        step(1'b0, 1'b0, 4'b0110);
        step(1'b0, 1'b0, 4'b1111);
        step(1'b0, 1'b1, 4'b1111);
        step(1'b0, 1'b0, 4'b1111);
        step(1'b0, 1'b0, 4'b1111);
        step(1'b0, 1'b1, 4'b1111);
        drain();

        // Mid-frame reset, then a clean frame two cycles later; rst beats start.
        step(1'b0, 1'b1, 4'b0110);
        step(1'b0, 1'b0, 4'b0110);
        step(1'b0, 1'b0, 4'b0110);
        step(1'b1, 1'b1, 4'b0110);
        step(1'b0, 1'b0, 4'b0110);
        step(1'b0, 1'b1, 4'b1001);
        drain();

        // All sixteen nibbles through the loopback detector.
        for (int n = 0; n < 16; n++) begin
            step(1'b0, 1'b1, 4'(n));
            drain();
        end

        // Random start/reset traffic.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
